// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and HI/LO-busy stalls, branch flush,
// mult/div occupancy tracking and a saturating stalled-cycle counter.
module hazard_ctrl #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_d,
  input  logic [4:0]  rt_d,
  input  logic [4:0]  rt_e,
  input  logic        memread_e,
  input  logic        md_start_e,
  input  logic        md_is_div_e,
  input  logic        hilo_use_d,
  input  logic        branch_taken_d,
  input  logic        clr_cnt,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        flush_e,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] stall_cnt
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  localparam logic [7:0] MUL_LD = 8'(MUL_CYCLES - 1);
  localparam logic [7:0] DIV_LD = 8'(DIV_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic       lu, mdh, stall;

  assign lu  = memread_e & (rt_e != 5'd0) & ((rt_e == rs_d) | (rt_e == rt_d));
  assign mdh = md_busy & hilo_use_d;

  // Reset masks every hazard output so inputs are ignored during rst.
  assign stall   = ~rst & (lu | mdh);
  assign stall_f = stall;
  assign stall_d = stall;
  assign flush_e = stall;
  assign flush_d = ~rst & branch_taken_d & ~stall;
  assign md_busy = ~rst & (state == MD_WAIT);
  assign md_done = ~rst & (state == MD_WAIT) & (cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= 8'd0;
      stall_cnt <= 32'd0;
    end else begin
      case (state)
        RUN: begin
          if (md_start_e) begin
            state <= MD_WAIT;
            cnt   <= md_is_div_e ? DIV_LD : MUL_LD;
          end
        end
        MD_WAIT: begin
          // New starts are dropped while the unit is occupied.
          if (cnt == 8'd0) state <= RUN;
          else             cnt   <= cnt - 8'd1;
        end
        default: state <= RUN;
      endcase

      if (clr_cnt)                    stall_cnt <= 32'd0;
      else if (stall && ~&stall_cnt)  stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule
